// File: rtl/syzygy_dac_pkg.sv
// Shared encodings and helpers for the SYZYGY DAC stream PHY.
// Optional ramp test pattern is enabled by SYZYGY_DAC_TEST_PATTERN_EN in the top.
package syzygy_dac_pkg;

    localparam int unsigned MAX_W = 32;

    typedef enum logic [1:0] {
        MODE_IQ     = 2'b00,
        MODE_I_ONLY = 2'b01,
        MODE_SWAP   = 2'b10,
        MODE_RAMP   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_RUN  = 2'b10
    } state_e;

    // Mid-scale code: half range in offset-binary, zero in two's complement
    function automatic logic [MAX_W-1:0] mid_value(input int unsigned width, input logic offset_bin);
        mid_value = '0;
        if (offset_bin && (width != 0)) begin
            mid_value = MAX_W'(1) << (width - 1);
        end
    endfunction

endpackage

// File: rtl/syzygy_dac_oddr_bank.sv
// Per-bit DDR output bank: ODDRE1 (SAME_EDGE, SRVAL 0) feeding an OBUF for each DAC pin.
module syzygy_dac_oddr_bank #(
    parameter int unsigned DATA_W = 12
) (
    input  logic              clk,
    input  logic              sr,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    output logic [DATA_W-1:0] q
);

    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
        logic q1_q;
        logic q2_q;

        // Both edge words are captured on the rising edge; the pad shows D1 high, D2 low
        always_ff @(posedge clk) begin
            if (sr) begin
                q1_q <= 1'b0;
                q2_q <= 1'b0;
            end else begin
                q1_q <= d1[b];
                q2_q <= d2[b];
            end
        end

        assign q[b] = clk ? q1_q : q2_q;
    end

endmodule

// File: rtl/syzygy_dac_stream_phy.sv
// I/Q stream to DDR DAC pins: FIFO, run-control FSM, channel mapping and ODDR bank.
// Define SYZYGY_DAC_TEST_PATTERN_EN to turn mode 11 into a ramp generator.
module syzygy_dac_stream_phy
    import syzygy_dac_pkg::*;
#(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned PRIME_LEVEL = FIFO_DEPTH / 2,
    parameter int unsigned UFLOW_W     = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [1:0]                    mode,
    input  logic                          offset_bin,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_W-1:0]             s_data_i,
    input  logic [DATA_W-1:0]             s_data_q,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          running,
    output logic [UFLOW_W-1:0]            uflow_count,
    output logic [DATA_W-1:0]             dac_d1,
    output logic [DATA_W-1:0]             dac_d2,
    output logic [DATA_W-1:0]             dac_data
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [DATA_W-1:0] MSB_MASK = DATA_W'(1) << (DATA_W - 1);

    state_e state_q, state_d;

    logic [PW-1:0]       wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d, level_d;
    logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [2*DATA_W-1:0] rd_pair;
    logic [DATA_W-1:0]   rd_i, rd_q, map_d1, map_d2, d1_d, d2_d, mid, fmt_mask;
    logic                empty, push, pop, uflow_evt, flush;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign push     = s_valid && s_ready;
    assign rd_pair  = mem_q[rd_ptr_q[AW-1:0]];
    assign rd_i     = rd_pair[DATA_W-1:0];
    assign rd_q     = rd_pair[2*DATA_W-1:DATA_W];
    assign mid      = DATA_W'(mid_value(DATA_W, offset_bin));
    assign fmt_mask = offset_bin ? MSB_MASK : '0;

    // Run control: prime to PRIME_LEVEL, pop every RUN cycle, fall back to FILL on underflow
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        uflow_evt = 1'b0;
        flush     = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            flush   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FILL;
                    flush   = 1'b1;
                end
                ST_FILL: begin
                    if (fifo_level >= PW'(PRIME_LEVEL)) begin
                        pop     = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (empty) begin
                        uflow_evt = 1'b1;
                        state_d   = ST_FILL;
                    end else begin
                        pop = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
        level_d  = wr_ptr_d - rd_ptr_d;
    end

`ifdef SYZYGY_DAC_TEST_PATTERN_EN
    logic [DATA_W-1:0] ramp_q;

    always_ff @(posedge clk) begin
        if (!reset_n || !enable || (state_q == ST_IDLE)) begin
            ramp_q <= '0;
        end else if (pop && (mode_e'(mode) == MODE_RAMP)) begin
            ramp_q <= ramp_q + DATA_W'(2);
        end
    end
`endif

    // Edge-word mapping of the popped pair; mode 11 falls back to IQ without the ramp
    always_comb begin
        map_d1 = rd_q;
        map_d2 = rd_i;
        case (mode_e'(mode))
            MODE_I_ONLY: begin
                map_d1 = rd_i;
                map_d2 = rd_i;
            end
            MODE_SWAP: begin
                map_d1 = rd_i;
                map_d2 = rd_q;
            end
`ifdef SYZYGY_DAC_TEST_PATTERN_EN
            MODE_RAMP: begin
                map_d1 = ramp_q;
                map_d2 = ramp_q + DATA_W'(1);
            end
`endif
            default: ;
        endcase
        d1_d = pop ? (map_d1 ^ fmt_mask) : mid;
        d2_d = pop ? (map_d2 ^ fmt_mask) : mid;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {s_data_q, s_data_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_level  <= '0;
            s_ready     <= 1'b0;
            running     <= 1'b0;
            uflow_count <= '0;
            dac_d1      <= mid;
            dac_d2      <= mid;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_level <= level_d;
            s_ready    <= (state_d != ST_IDLE) && (level_d != PW'(FIFO_DEPTH));
            running    <= (state_d == ST_RUN);
            if (uflow_evt && !(&uflow_count)) begin
                uflow_count <= uflow_count + UFLOW_W'(1);
            end
            dac_d1 <= d1_d;
            dac_d2 <= d2_d;
        end
    end

    syzygy_dac_oddr_bank #(
        .DATA_W (DATA_W)
    ) u_oddr (
        .clk (clk),
        .sr  (~reset_n),
        .d1  (dac_d1),
        .d2  (dac_d2),
        .q   (dac_data)
    );

endmodule

// File: tb/tb_syzygy_dac_stream_phy.sv
// Bench for syzygy_dac_stream_phy: queue-based model checked every cycle plus directed literals.
module tb_syzygy_dac_stream_phy;

    localparam int DEPTH = 8;
    localparam int PRIME = 4;
`ifdef SYZYGY_DAC_TEST_PATTERN_EN
    localparam bit RAMP_ON = 1'b1;
`else
    localparam bit RAMP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, enable, offset_bin, s_valid, s_ready, running;
    logic [1:0]  mode;
    logic [11:0] s_data_i, s_data_q, dac_d1, dac_d2, dac_data;
    logic [3:0]  fifo_level;
    logic [15:0] uflow_count;

    logic        en2, valid2, ready2, running2;
    logic [1:0]  mode2, uflow2;
    logic        offset2;
    logic [11:0] i2, q2, d1_2, d2_2, pins2;
    logic [3:0]  level2;

    syzygy_dac_stream_phy #(.DATA_W(12), .FIFO_DEPTH(8), .PRIME_LEVEL(4), .UFLOW_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .offset_bin(offset_bin),
        .s_valid(s_valid), .s_ready(s_ready), .s_data_i(s_data_i), .s_data_q(s_data_q),
        .fifo_level(fifo_level), .running(running), .uflow_count(uflow_count),
        .dac_d1(dac_d1), .dac_d2(dac_d2), .dac_data(dac_data));

    syzygy_dac_stream_phy #(.DATA_W(12), .FIFO_DEPTH(8), .PRIME_LEVEL(8), .UFLOW_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .enable(en2), .mode(mode2), .offset_bin(offset2),
        .s_valid(valid2), .s_ready(ready2), .s_data_i(i2), .s_data_q(q2),
        .fifo_level(level2), .running(running2), .uflow_count(uflow2),
        .dac_d1(d1_2), .dac_d2(d2_2), .dac_data(pins2));

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: state as 0 idle / 1 fill / 2 run, FIFO as a queue of {q,i}
    int          m_st;
    logic [23:0] mq[$];
    logic [15:0] m_uf;
    logic [11:0] exp_d1, exp_d2, pin_hi, pin_lo, m_ramp;

    function automatic logic [23:0] map_words(input logic [1:0] md, input logic ob,
                                              input logic [23:0] pr, input logic [11:0] rp);
        logic [11:0] i, q, a, b;
        i = pr[11:0];
        q = pr[23:12];
        case (md)
            2'd1:    begin a = i; b = i; end
            2'd2:    begin a = i; b = q; end
            2'd3:    if (RAMP_ON) begin a = rp; b = rp + 12'd1; end else begin a = q; b = i; end
            default: begin a = q; b = i; end
        endcase
        if (ob) begin
            a[11] = ~a[11];
            b[11] = ~b[11];
        end
        return {a, b};
    endfunction

    always @(posedge clk) begin
        logic        rdy_pre, do_push, popped;
        logic [11:0] mid;
        logic [23:0] pr, w;
        rdy_pre = (m_st != 0) && (mq.size() < DEPTH);
        do_push = s_valid && rdy_pre;
        popped  = 1'b0;
        pr      = '0;
        mid     = offset_bin ? 12'h800 : 12'h000;
        if (!reset_n) begin
            pin_hi = '0; pin_lo = '0;
            m_st = 0; mq.delete(); m_uf = '0; m_ramp = '0;
            exp_d1 = mid; exp_d2 = mid;
        end else begin
            pin_hi = exp_d1; pin_lo = exp_d2;
            exp_d1 = mid; exp_d2 = mid;
            if (!enable) begin
                m_st = 0; mq.delete(); m_ramp = '0;
            end else begin
                if (m_st == 0) begin
                    m_st = 1; m_ramp = '0;
                end else if (mq.size() > 0 && (m_st == 2 || mq.size() >= PRIME)) begin
                    pr = mq.pop_front(); popped = 1'b1; m_st = 2;
                end else if (m_st == 2) begin
                    if (m_uf != 16'hFFFF) m_uf = m_uf + 16'd1;
                    m_st = 1;
                end
                if (popped) begin
                    w = map_words(mode, offset_bin, pr, m_ramp);
                    exp_d1 = w[23:12];
                    exp_d2 = w[11:0];
                    if (RAMP_ON && mode == 2'd3) m_ramp = m_ramp + 12'd2;
                end
                if (do_push) mq.push_back({s_data_q, s_data_i});
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("level", 32'(fifo_level), 32'(mq.size()));
            chk("running", 32'(running), 32'(m_st == 2));
            chk("s_ready", 32'(s_ready), 32'((m_st != 0) && (mq.size() < DEPTH)));
            chk("uflow", 32'(uflow_count), 32'(m_uf));
            chk("tap_d1", 32'(dac_d1), 32'(exp_d1));
            chk("tap_d2", 32'(dac_d2), 32'(exp_d2));
            chk("pin_rise", 32'(dac_data), 32'(pin_hi));
        end
    end

    always @(negedge clk) begin
        #1;
        if (cmp_en) chk("pin_fall", 32'(dac_data), 32'(pin_lo));
    end

    task automatic push1(input logic [11:0] i, input logic [11:0] q, input bit on2);
        logic rdy;
        rdy = 1'b0;
        if (on2) begin valid2 = 1'b1; i2 = i; q2 = q; end
        else begin s_valid = 1'b1; s_data_i = i; s_data_q = q; end
        for (int n = 0; n < 64; n++) begin
            rdy = on2 ? ready2 : s_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy) break;
        end
        if (!rdy) begin
            total++; bad++;
            $display("FAIL push_timeout: got ready=0 expected ready=1 at %0t", $time);
        end
        if (on2) valid2 = 1'b0; else s_valid = 1'b0;
    endtask

    task automatic wait_run(input bit want, input bit on2);
        logic r;
        r = ~want;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            r = on2 ? running2 : running;
            if (r == want) break;
        end
        if (r != want) begin
            total++; bad++;
            $display("FAIL wait_running: got %0d expected %0d at %0t", r, want, $time);
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; mode = 2'd0; offset_bin = 1'b0;
        s_valid = 1'b0; s_data_i = '0; s_data_q = '0;
        en2 = 1'b0; valid2 = 1'b0; i2 = '0; q2 = '0; mode2 = 2'd0; offset2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_uflow", 32'(uflow_count), 32'd0);
        chk("rst_d1", 32'(dac_d1), 32'h000);
        cmp_en = 1'b1;
        reset_n = 1'b1;
        offset_bin = 1'b1;
        @(posedge clk); #1;
        chk("idle_mid_d1", 32'(dac_d1), 32'h800);
        chk("idle_mid_d2", 32'(dac_d2), 32'h800);
        @(negedge clk);
        offset_bin = 1'b0;
        enable = 1'b1;

        // Prime with four pairs in IQ mode
        push1(12'h123, 12'h456, 1'b0);
        push1(12'h111, 12'h222, 1'b0);
        push1(12'h333, 12'h444, 1'b0);
        push1(12'h555, 12'h666, 1'b0);
        chk("prime_level", 32'(fifo_level), 32'd4);
        chk("prime_not_run", 32'(running), 32'd0);
        @(posedge clk); #1;
        chk("run_rise", 32'(running), 32'd1);
        chk("first_d1", 32'(dac_d1), 32'h456);
        chk("first_d2", 32'(dac_d2), 32'h123);
        @(posedge clk); #1;
        chk("pin_first_hi", 32'(dac_data), 32'h456);
        @(negedge clk); #1;
        chk("pin_first_lo", 32'(dac_data), 32'h123);
        wait_run(1'b0, 1'b0);
        chk("uflow_one", 32'(uflow_count), 32'd1);
        chk("uflow_mid", 32'(dac_d1), 32'h000);

        // Refill resumes RUN, then drain again
        @(negedge clk);
        for (int k = 0; k < 4; k++) push1(12'(k * 16 + 7), 12'(k * 16 + 9), 1'b0);
        wait_run(1'b1, 1'b0);
        wait_run(1'b0, 1'b0);
        chk("uflow_two", 32'(uflow_count), 32'd2);

        // Offset-binary conversion in I-only mode
        @(negedge clk);
        mode = 2'd1; offset_bin = 1'b1;
        push1(12'h000, 12'h0AA, 1'b0);
        push1(12'h7FF, 12'h000, 1'b0);
        push1(12'h800, 12'h000, 1'b0);
        push1(12'h001, 12'h000, 1'b0);
        wait_run(1'b1, 1'b0);
        chk("ob_zero", 32'(dac_d1), 32'h800);
        @(posedge clk); #1;
        chk("ob_max", 32'(dac_d1), 32'hFFF);
        wait_run(1'b0, 1'b0);
        chk("ob_uflow_mid", 32'(dac_d2), 32'h800);

        // Mode 11: ramp when enabled, otherwise same as IQ
        @(negedge clk);
        mode = 2'd3; offset_bin = 1'b0;
        push1(12'h0AB, 12'h0CD, 1'b0);
        for (int k = 0; k < 3; k++) push1(12'(k), 12'(k + 1), 1'b0);
        wait_run(1'b1, 1'b0);
        chk("mode3_d1", 32'(dac_d1), RAMP_ON ? 32'h000 : 32'h0CD);
        chk("mode3_d2", 32'(dac_d2), RAMP_ON ? 32'h001 : 32'h0AB);
        wait_run(1'b0, 1'b0);

        // Continuous stream of 1000 pairs across all modes
        @(negedge clk);
        for (int k = 0; k < 1000; k++) begin
            if (k % 250 == 0) mode = 2'(k / 250);
            push1(12'($urandom), 12'($urandom), 1'b0);
        end
        chk("stream_level", 32'(fifo_level), 32'd4);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("dis_level", 32'(fifo_level), 32'd0);
        chk("dis_ready", 32'(s_ready), 32'd0);
        chk("dis_running", 32'(running), 32'd0);
        chk("dis_uflow_kept", 32'(uflow_count), 32'd4);

        // Second instance: full FIFO, mid-RUN disable and saturation
        @(negedge clk);
        en2 = 1'b1;
        for (int k = 0; k < 8; k++) push1(12'(k), 12'(k + 8), 1'b1);
        chk("full_level", 32'(level2), 32'd8);
        chk("full_ready", 32'(ready2), 32'd0);
        @(posedge clk); #1;
        chk("full_run_level", 32'(level2), 32'd7);
        chk("full_run_ready", 32'(ready2), 32'd1);
        chk("full_run_d1", 32'(d1_2), 32'h008);
        for (int n = 0; n < 20 && level2 != 4'd5; n++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("mid_run_level", 32'(level2), 32'd5);
        en2 = 1'b0;
        @(posedge clk); #1;
        chk("off_level", 32'(level2), 32'd0);
        chk("off_ready", 32'(ready2), 32'd0);
        chk("off_running", 32'(running2), 32'd0);
        chk("off_mid", 32'(d1_2), 32'h000);
        @(negedge clk);
        en2 = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 8; k++) push1(12'(r), 12'(k), 1'b1);
            wait_run(1'b0, 1'b1);
            chk("sat_uflow", 32'(uflow2), (r < 3) ? 32'(r + 1) : 32'd3);
        end

        // Mid-RUN synchronous reset
        @(negedge clk);
        enable = 1'b1; mode = 2'd0;
        for (int k = 0; k < 4; k++) push1(12'(k + 3), 12'(k + 5), 1'b0);
        @(posedge clk); #1;
        chk("pre_rst_run", 32'(running), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_run_level", 32'(fifo_level), 32'd0);
        chk("rst_run_ready", 32'(s_ready), 32'd0);
        chk("rst_run_running", 32'(running), 32'd0);
        chk("rst_run_uflow", 32'(uflow_count), 32'd0);
        chk("rst_run_mid", 32'(dac_d1), 32'h000);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
